// File: rtl/tx_req_arbiter.sv
// tx_req_arbiter: round-robin, packet-granular arbiter that feeds the
// TCP packet sender through a one-deep registered output stage.
module tx_req_arbiter #(
  parameter int N = 4,
  parameter int W = 545,
  localparam int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] s_req_TDATA,
  input  logic [N-1:0]   s_req_TVALID,
  output logic [N-1:0]   s_req_TREADY,
  input  logic [N-1:0]   req_mask,
  output logic [W-1:0]   m_pkt_TDATA,
  output logic           m_pkt_TVALID,
  input  logic           m_pkt_TREADY,
  output logic [GW-1:0]  grant_id,
  output logic           busy,
  output logic [31:0]    pkt_count
);

  localparam int TL = W - 33;

  typedef enum logic {
    ARB,
    XFER
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] r_grant;
  logic [W-1:0]  r_tdata;
  logic          r_tvalid;
  logic [31:0]   r_cnt;

  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_ready;
  logic [GW-1:0] w_sel;
  logic [W-1:0]  w_beat;
  logic          w_any;
  logic          w_free;
  logic          w_acc;
  logic          w_last;
  logic          w_drain;
  int            w_idx;

  // Walk downward so the nearest index after rr_ptr is written last.
  always_comb begin
    w_elig = s_req_TVALID & req_mask;
    w_any  = |w_elig;
    w_sel  = '0;
    w_idx  = 0;
    for (int k = N; k >= 1; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % N;
      if (|(w_elig & (N'(1) << w_idx))) begin
        w_sel = GW'(w_idx);
      end
    end
  end

  always_comb begin
    w_beat = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant == GW'(i)) begin
        w_beat = s_req_TDATA[i*W +: W];
      end
    end
  end

  always_comb begin
    w_free  = !r_tvalid | m_pkt_TREADY;
    w_drain = r_tvalid & m_pkt_TREADY;
    w_ready = '0;
    if (r_state == XFER) begin
      w_ready[r_grant] = w_free;
    end
    w_acc  = |(w_ready & s_req_TVALID);
    w_last = w_beat[TL];
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB:  if (w_any) w_state_nxt = XFER;
      XFER: if (w_acc && w_last) w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= GW'(N - 1);
      r_grant  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (r_state == ARB && w_any) begin
        r_grant <= w_sel;
      end
      if (w_acc && w_last) begin
        r_rr_ptr <= r_grant;
      end
      if (w_acc) begin
        r_tdata  <= w_beat;
        r_tvalid <= 1'b1;
      end else if (m_pkt_TREADY) begin
        r_tvalid <= 1'b0;
      end
      if (w_drain && r_tdata[TL]) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign s_req_TREADY = w_ready;
  assign m_pkt_TDATA  = r_tdata;
  assign m_pkt_TVALID = r_tvalid;
  assign grant_id     = r_grant;
  assign busy         = (r_state == XFER);
  assign pkt_count    = r_cnt;

endmodule

// File: doc/tx_req_arbiter.md
# tx_req_arbiter

Round-robin, packet-granular arbiter that shares the single TCP transmit path among N requester streams. It sits directly upstream of the packet-sender stage. Each requester presents beats in the packet-sender input format; the arbiter forwards exactly one whole packet at a time through a one-deep registered output stage. It also provides per-requester enable masking and a transmitted-packet counter for host visibility.

## Interface
- N, default 4: number of requesters, 2..8.
- W, default 545: beat width; bits [544:513] metadata (session id in [528:513]), bit [512] tlast, bits [511:0] payload.
- clk  in  1  single clock domain.
- rst  in  1  synchronous, active-high reset.
- s_req_TDATA  in  N*W  requester i occupies bits [i*W +: W].
- s_req_TVALID  in  N  per-requester valid.
- s_req_TREADY  out  N  per-requester ready; at most one bit high in any cycle.
- req_mask  in  N  1 = requester eligible for new grants.
- m_pkt_TDATA  out  W  registered beat to packet sender.
- m_pkt_TVALID  out  1  registered valid.
- m_pkt_TREADY  in  1  downstream ready.
- grant_id  out  clog2(N)  index of current/last granted requester.
- busy  out  1  high while in XFER.
- pkt_count  out  32  packets delivered downstream (tlast beats accepted on m_pkt).

## Operation
- States: ARB, XFER.
- ARB: eligible = s_req_TVALID & req_mask. If none, stay in ARB. Otherwise select the first eligible index searching rr_ptr+1, rr_ptr+2, … modulo N. Register it in grant_id and go to XFER. No beat is accepted in ARB; all s_req_TREADY are 0.
- XFER: s_req_TREADY[grant_id] = slot_free, where slot_free = !m_pkt_TVALID | m_pkt_TREADY. All other ready bits are 0.
- On an accepted input beat (valid & ready), load the output register with that beat and set m_pkt_TVALID.
- If an accepted beat has tlast = 1: set rr_ptr <= grant_id and return to ARB next cycle.
- The grant is held until tlast. Changes to req_mask or TVALID mid-packet do not abort the packet.
- Output register: when m_pkt_TVALID & m_pkt_TREADY and no new beat is loaded, clear m_pkt_TVALID. Data is held stable while valid and not ready.
- pkt_count increments by 1 on each m_pkt handshake with TDATA[512] = 1. Wraps modulo 2^32.
- The arbiter does not modify beats; it is a pure pass-through of all W bits.

## Timing
- Reset values: state = ARB, rr_ptr = N-1 (so requester 0 wins first), grant_id = 0, busy = 0, m_pkt_TVALID = 0, m_pkt_TDATA = 0, pkt_count = 0, s_req_TREADY = 0.
- Arbitration takes 1 cycle: a requester valid in cycle t (in ARB) sees TREADY in t+1 if downstream is free.
- Input-to-output latency: 1 cycle.
- Packet spacing: single-beat packets from continuously valid requesters produce one beat every 2 cycles (ARB + XFER). Multi-beat packets stream at 1 beat/cycle after the ARB cycle.
- Full throughput within a packet when m_pkt_TREADY is held high. Simultaneous output drain and input load in the same cycle is required.
- Back-pressure: with m_pkt_TREADY = 0 and the output register full, granted TREADY = 0. No beat is dropped or duplicated.
- Simultaneous events:
  - tlast accepted in the same cycle the output drains → both take effect.
  - Requester deasserts TVALID mid-packet → stay in XFER, wait.
- All masked or no valid → remain in ARB indefinitely. busy = 0.
- rst asserted mid-packet → all state returns to reset values the next cycle. Any partially forwarded packet is abandoned; the output register is cleared.

## Test plan
- Reset, then requester 2 alone sends one single-beat packet (session 0x0005, tlast = 1) → TREADY[2] high 1 cycle after valid; m_pkt beat identical 1 cycle later; pkt_count = 1; grant_id = 2.
- All 4 requesters continuously valid, single-beat packets, m_pkt_TREADY = 1 → grant order 0,1,2,3,0,…; one output beat every 2 cycles; pkt_count = 8 after 16 cycles of XFER/ARB.
- Requester 1 sends a 3-beat packet while requester 0 is valid → beats 1a,1b,1c contiguous on output; requester 0 granted only after 1c.
- m_pkt_TREADY = 0 for 5 cycles mid-packet → m_pkt_TDATA stable; s_req_TREADY all 0; no loss after release.
- req_mask = 4'b1010, all valid → only requesters 1 and 3 alternate. Clearing mask bit 1 mid-packet still completes that packet.
- rst pulsed during the second beat of a 4-beat packet → next cycle m_pkt_TVALID = 0, pkt_count = 0, state ARB, and requester 0 is granted first afterward.
